// File: rtl/axa_undo_stack_if.sv
// Request/response bundle for the undo stack: push/pop/peek requests in,
// registered read result plus occupancy and pulse flags out.
interface axa_undo_stack_if #(
  parameter int WIDTH = 16,
  parameter int PTRW  = 4
) ();
  logic             clr;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             peek;
  logic [PTRW-1:0]  peek_off;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [PTRW-1:0]  usp;
  logic [PTRW:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, push, push_data, pop, peek, peek_off,
    input  rd_valid, rd_data, usp, count, empty, full, overflow, underflow
  );
  modport slave (
    input  clr, push, push_data, pop, peek, peek_off,
    output rd_valid, rd_data, usp, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/axa_undo_stack.sv
// Circular LIFO of values saved before destructive updates. Pushes overwrite
// the oldest entry when full; pop/peek read with one cycle of latency.
module axa_undo_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTRW  = 4
) (
  input logic              clk,
  input logic              reset,
  axa_undo_stack_if.slave  bus
);
  localparam logic [PTRW:0] CNT_MAX = (PTRW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  usp_q, usp_d, top, pidx, waddr;
  logic [PTRW:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvld_q, ovf_q, udf_q;
  logic             rvld_d, ovf_d, udf_d;
  logic             is_empty, is_full;
  logic             pop_ok, pop_udf, peek_act, peek_ok, we;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_MAX);
  assign top      = usp_q - 1'b1;
  assign pidx     = usp_q - bus.peek_off - 1'b1;

  always_comb begin
    pop_ok   = !bus.clr && bus.pop && !is_empty;
    pop_udf  = !bus.clr && bus.pop && is_empty;
    peek_act = !bus.clr && bus.peek && !bus.pop;
    peek_ok  = peek_act && ({1'b0, bus.peek_off} < cnt_q);
    we       = !bus.clr && bus.push;
    // A push paired with a live pop replaces the top entry in place.
    waddr    = pop_ok ? top : usp_q;

    usp_d   = usp_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;

    if (bus.clr) begin
      usp_d = '0;
      cnt_d = '0;
    end else begin
      if (pop_ok) begin
        rdata_d = mem[top];
        rvld_d  = 1'b1;
        if (!bus.push) begin
          usp_d = usp_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end else if (peek_ok) begin
        rdata_d = mem[pidx];
        rvld_d  = 1'b1;
      end
      udf_d = pop_udf || (peek_act && !peek_ok);
      if (bus.push && !pop_ok) begin
        usp_d = usp_q + 1'b1;
        if (is_full) ovf_d = 1'b1;
        else         cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      usp_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      usp_q   <= usp_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.push_data;
  end

  assign bus.usp       = usp_q;
  assign bus.count     = cnt_q;
  assign bus.rd_data   = rdata_q;
  assign bus.rd_valid  = rvld_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
endmodule

// File: tb/tb_axa_undo_stack.sv
// Directed checks for axa_undo_stack: vector table plus overflow,
// wraparound and asynchronous-reset sequences.
module tb_axa_undo_stack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axa_undo_stack_if #(.WIDTH(16), .PTRW(4)) bus ();
  axa_undo_stack #(.WIDTH(16), .DEPTH(16), .PTRW(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic        clr, push;
    logic [15:0] pd;
    logic        pop, peek;
    logic [3:0]  off;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  eusp;
    logic [4:0]  ecnt;
    logic        eov, eun;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic c, input logic p, input logic [15:0] d,
                       input logic po, input logic pk, input logic [3:0] o);
    bus.clr = c; bus.push = p; bus.push_data = d;
    bus.pop = po; bus.peek = pk; bus.peek_off = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(0, 0, 16'h0, 0, 0, 4'h0);
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".rd_valid"},  32'(bus.rd_valid),  32'(v.ev));
    chk({tag, ".rd_data"},   32'(bus.rd_data),   32'(v.ed));
    chk({tag, ".usp"},       32'(bus.usp),       32'(v.eusp));
    chk({tag, ".count"},     32'(bus.count),     32'(v.ecnt));
    chk({tag, ".empty"},     32'(bus.empty),     32'(v.ecnt == 5'd0));
    chk({tag, ".full"},      32'(bus.full),      32'(v.ecnt == 5'd16));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(v.eov));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(v.eun));
  endtask

  initial begin
    vec_t z;
    drive(0, 0, 16'h0, 0, 0, 4'h0);
    //                 clr push pd       pop peek off  ev ed       usp  cnt   ov un
    tv.push_back('{0, 1, 16'h1111, 0, 0, 4'd0, 0, 16'h0000, 4'd1, 5'd1, 0, 0});
    tv.push_back('{0, 1, 16'h2222, 0, 0, 4'd0, 0, 16'h0000, 4'd2, 5'd2, 0, 0});
    tv.push_back('{0, 1, 16'h3333, 0, 0, 4'd0, 0, 16'h0000, 4'd3, 5'd3, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 1, 16'h3333, 4'd2, 5'd2, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 0, 0, 4'd0, 0, 16'h3333, 4'd2, 5'd2, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 1, 16'h2222, 4'd1, 5'd1, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 1, 16'h1111, 4'd0, 5'd0, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 0, 16'h1111, 4'd0, 5'd0, 0, 1});
    tv.push_back('{0, 0, 16'h0000, 0, 1, 4'd0, 0, 16'h1111, 4'd0, 5'd0, 0, 1});
    tv.push_back('{0, 1, 16'hAAAA, 0, 0, 4'd0, 0, 16'h1111, 4'd1, 5'd1, 0, 0});
    tv.push_back('{0, 1, 16'hBBBB, 0, 0, 4'd0, 0, 16'h1111, 4'd2, 5'd2, 0, 0});
    tv.push_back('{0, 1, 16'hCCCC, 1, 0, 4'd0, 1, 16'hBBBB, 4'd2, 5'd2, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 1, 16'hCCCC, 4'd1, 5'd1, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 1, 16'hAAAA, 4'd0, 5'd0, 0, 0});
    tv.push_back('{0, 1, 16'h5555, 1, 0, 4'd0, 0, 16'hAAAA, 4'd1, 5'd1, 0, 1});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 1, 16'h5555, 4'd0, 5'd0, 0, 0});
    tv.push_back('{0, 1, 16'h0001, 0, 0, 4'd0, 0, 16'h5555, 4'd1, 5'd1, 0, 0});
    tv.push_back('{0, 1, 16'h0002, 0, 0, 4'd0, 0, 16'h5555, 4'd2, 5'd2, 0, 0});
    tv.push_back('{0, 1, 16'h0003, 0, 0, 4'd0, 0, 16'h5555, 4'd3, 5'd3, 0, 0});
    tv.push_back('{0, 1, 16'h0004, 0, 0, 4'd0, 0, 16'h5555, 4'd4, 5'd4, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 0, 1, 4'd2, 1, 16'h0002, 4'd4, 5'd4, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 0, 1, 4'd0, 1, 16'h0004, 4'd4, 5'd4, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 0, 1, 4'd4, 0, 16'h0004, 4'd4, 5'd4, 0, 1});
    // peek alongside push uses the pre-push pointer: index 4-3-1 = 0
    tv.push_back('{0, 1, 16'h0005, 0, 1, 4'd3, 1, 16'h0001, 4'd5, 5'd5, 0, 0});
    // pop with peek: peek ignored, pop wins
    tv.push_back('{0, 0, 16'h0000, 1, 1, 4'd4, 1, 16'h0005, 4'd4, 5'd4, 0, 0});
    tv.push_back('{1, 1, 16'h9999, 1, 1, 4'd0, 0, 16'h0005, 4'd0, 5'd0, 0, 0});
    tv.push_back('{0, 0, 16'h0000, 1, 0, 4'd0, 0, 16'h0005, 4'd0, 5'd0, 0, 1});

    // Reset state before any clock edge.
    #2;
    z = '{0, 0, 16'h0, 0, 0, 4'd0, 0, 16'h0000, 4'd0, 5'd0, 0, 0};
    chk_all("reset", z);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      drive(tv[i].clr, tv[i].push, tv[i].pd, tv[i].pop, tv[i].peek, tv[i].off);
      tick();
      chk_all($sformatf("vec%0d", i), tv[i]);
    end

    // Overflow: 17 pushes from empty, only the last one overwrites.
    for (int k = 0; k < 17; k++) begin
      drive(0, 1, 16'(k), 0, 0, 4'd0);
      tick();
      chk($sformatf("ovf_push%0d.overflow", k), 32'(bus.overflow), 32'(k == 16));
      chk($sformatf("ovf_push%0d.count", k), 32'(bus.count), (k == 16) ? 32'd16 : 32'(k + 1));
    end
    chk("ovf.usp", 32'(bus.usp), 32'd1);
    chk("ovf.full", 32'(bus.full), 32'd1);
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 16'h0, 1, 0, 4'd0);
      tick();
      chk($sformatf("ovf_pop%0d.rd_valid", k), 32'(bus.rd_valid), 32'd1);
      chk($sformatf("ovf_pop%0d.rd_data", k), 32'(bus.rd_data), 32'(16 - k));
      chk($sformatf("ovf_pop%0d.overflow", k), 32'(bus.overflow), 32'd0);
    end
    chk("ovf_drain.count", 32'(bus.count), 32'd0);
    chk("ovf_drain.usp", 32'(bus.usp), 32'd1);
    drive(0, 0, 16'h0, 1, 0, 4'd0);
    tick();
    chk("ovf_pop16.underflow", 32'(bus.underflow), 32'd1);
    chk("ovf_pop16.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("ovf_pop16.rd_data", 32'(bus.rd_data), 32'd1);
    tick();
    chk("pulse_clear.underflow", 32'(bus.underflow), 32'd0);

    // Asynchronous reset in the middle of a push cycle.
    drive(0, 1, 16'h4242, 0, 0, 4'd0);
    tick();
    drive(0, 0, 16'h0, 1, 0, 4'd0);
    tick();
    chk("pre_rst.rd_data", 32'(bus.rd_data), 32'h4242);
    drive(0, 1, 16'h6666, 0, 0, 4'd0);
    #2;
    reset = 1'b0;
    #1;
    z = '{0, 0, 16'h0, 0, 0, 4'd0, 0, 16'h0000, 4'd0, 5'd0, 0, 0};
    chk_all("async_rst", z);
    drive(0, 0, 16'h0, 0, 0, 4'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    drive(0, 1, 16'h7777, 0, 0, 4'd0);
    tick();
    chk("post_rst.usp", 32'(bus.usp), 32'd1);
    chk("post_rst.count", 32'(bus.count), 32'd1);
    drive(0, 0, 16'h0, 1, 0, 4'd0);
    tick();
    chk("post_rst.rd_data", 32'(bus.rd_data), 32'h7777);
    chk("post_rst.empty", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
